// File: rtl/nibble_serial_adder16_if.sv
// Operand/result handshake bundle for nibble_serial_adder16.
// Carries the optional sub input when NIBBLE_SERIAL_SUB_EN is defined.
interface nibble_serial_adder16_if #(
  parameter int unsigned N_NIB = 4
);
  localparam int unsigned W = 4 * N_NIB;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         out_ready;

  modport slave (
`ifdef NIBBLE_SERIAL_SUB_EN
    input  sub,
`endif
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
    output sum,
    output cout,
    output out_valid,
    input  out_ready
  );

  modport master (
`ifdef NIBBLE_SERIAL_SUB_EN
    output sub,
`endif
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
    input  sum,
    input  cout,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/nibble_serial_adder16.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice processes one nibble per cycle.
// Define NIBBLE_SERIAL_SUB_EN to add the sub input (a - b using ~b and carry-in 1).
module nibble_serial_adder16 #(
  parameter int unsigned N_NIB = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  nibble_serial_adder16_if.slave   bus_io
);
  localparam int unsigned W    = 4 * N_NIB;
  localparam int unsigned IdxW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;

  logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_c, nib_s;
  logic       nib_co;
  logic       last_nib;

  assign nib_a    = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b    = b_q[{idx_q, 2'b00} +: 4];
  assign last_nib = (idx_q == IdxW'(N_NIB - 1));

  // 4-bit carry-lookahead slice; all carries expressed from generate/propagate and carry_q.
  always_comb begin
    nib_g  = nib_a & nib_b;
    nib_p  = nib_a ^ nib_b;
    nib_c  = {nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0]) |
                (nib_p[2] & nib_p[1] & nib_p[0] & carry_q),
              nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q),
              nib_g[0] | (nib_p[0] & carry_q),
              carry_q};
    nib_co = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1]) |
             (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0]) |
             (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    nib_s  = nib_p ^ nib_c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_d     = bus_io.a;
`ifdef NIBBLE_SERIAL_SUB_EN
          // Subtraction folds into the adder: invert b at capture and force carry-in.
          b_d     = bus_io.sub ? ~bus_io.b : bus_io.b;
          carry_d = bus_io.sub ? 1'b1 : bus_io.cin;
`else
          b_d     = bus_io.b;
          carry_d = bus_io.cin;
`endif
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_co;
        idx_d   = idx_q + IdxW'(1);
        if (last_nib) begin
          cout_d  = nib_co;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Scoreboard bench for nibble_serial_adder16: stimulus pushes expected {cout,sum},
// a negedge monitor pops and compares on every out_valid & out_ready handshake.
module tb_nibble_serial_adder16;
  localparam int unsigned N_NIB = 4;
  localparam int unsigned W     = 4 * N_NIB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_adder16_if #(.N_NIB(N_NIB)) bus ();

  nibble_serial_adder16 #(.N_NIB(N_NIB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  logic [W:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic rand_mode   = 1'b0;
  logic ready_force = 1'b1;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sole driver of out_ready; offset from the edge so it never races the stimulus.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("no_bypass", {16'h0, bus.in_ready & bus.out_valid}, '0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %h expected none", {bus.cout, bus.sum});
          end else begin
            e = exp_q.pop_front();
            check("result", {bus.cout, bus.sum}, e);
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input logic push);
    int t;
    logic [W:0] e;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    if (sub) e = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else     e = {1'b0, a} + {1'b0, b} + {16'h0, cin};
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub = sub;
`endif
    bus.in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("wait_out_valid", {16'h0, bus.out_valid}, 17'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    bus.sub      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {16'h0, bus.out_valid}, 17'd0);
    check("rst_result", {bus.cout, bus.sum}, 17'h0);
    rst_n = 1'b1;
    check("rst_in_ready", {16'h0, bus.in_ready}, 17'd1);

    // Basic op with latency check: capture edge k, out_valid high after edge k+4.
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("latency_low", {16'h0, bus.out_valid}, 17'd0);
    end
    @(posedge clk);
    #1;
    check("latency_high", {16'h0, bus.out_valid}, 17'd1);
    @(posedge clk);
    #1;
    check("in_ready_after", {16'h0, bus.in_ready}, 17'd1);

    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-pressure: result must hold while out_ready is low; extra in_valid is ignored.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {16'h0, bus.out_valid}, 17'd1);
      check("stall_result", {bus.cout, bus.sum}, 17'h10000);
      if (i == 2) begin
        bus.a        = 16'h0001;
        bus.b        = 16'h0001;
        bus.in_valid = 1'b1;
      end
      if (i == 3) bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    ready_force  = 1'b1;
    drain();

    // Reset mid-RUN aborts; the operand after reset is accepted on the first edge.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {16'h0, bus.out_valid}, 17'd0);
    check("abort_result", {bus.cout, bus.sum}, 17'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
    drain();

`ifdef NIBBLE_SERIAL_SUB_EN
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
    drain();
`endif

    // Random operands with random input gaps and output stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    rand_mode = 1'b0;
    drain();
    check("queue_empty", 17'(exp_q.size()), 17'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
